// File: rtl/ifu_axi_rd.sv
// Read-only AXI4-Lite master for instruction fetch: one AR/R per request,
// misaligned rejection, R-channel timeout with drain, and a one-deep pending slot.
//
// state   | meaning
// S_IDLE  | waiting for a fetch request
// S_ADDR  | AR valid, waiting for m_arready
// S_DATA  | R ready, waiting for m_rvalid or timeout
// S_DRAIN | timed out; swallowing the late R beat
module ifu_axi_rd #(
  parameter int TIMEOUT = 1024,
  parameter int ADDR_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_reqValid,
  input  logic [ADDR_W-1:0] io_addr,
  output logic              io_respValid,
  output logic [31:0]       io_rdata,
  output logic              io_err,
  output logic              busy,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              resp_q, resp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_v, pend_v_d;
  logic [ADDR_W-1:0] pend_addr, pend_addr_d;

  logic req_aligned, req_misaligned;
  logic unused_rresp;

  assign req_aligned    = io_reqValid && (io_addr[1:0] == 2'b00);
  assign req_misaligned = io_reqValid && (io_addr[1:0] != 2'b00);
  assign unused_rresp   = m_rresp[0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    resp_d      = 1'b0;
    cnt_d       = cnt_q;
    pend_v_d    = pend_v;
    pend_addr_d = pend_addr;
    case (state_q)
      S_IDLE: begin
        if (req_misaligned) begin
          resp_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else if (req_aligned) begin
          addr_d  = io_addr;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_arready) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (m_rvalid) begin
          rdata_d = m_rdata;
          err_d   = m_rresp[1];
          resp_d  = 1'b1;
          state_d = S_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          resp_d  = 1'b1;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (req_misaligned) begin
          resp_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
        // A request landing together with the late beat goes straight to ADDR.
        if (m_rvalid) begin
          if (pend_v) begin
            addr_d   = pend_addr;
            pend_v_d = 1'b0;
            state_d  = S_ADDR;
          end else if (req_aligned) begin
            addr_d  = io_addr;
            state_d = S_ADDR;
          end else begin
            state_d = S_IDLE;
          end
        end else if (req_aligned && !pend_v) begin
          pend_v_d    = 1'b1;
          pend_addr_d = io_addr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      resp_q    <= 1'b0;
      cnt_q     <= '0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      pend_v    <= pend_v_d;
      pend_addr <= pend_addr_d;
    end
  end

  assign io_respValid = resp_q;
  assign io_rdata     = rdata_q;
  assign io_err       = err_q;
  assign busy         = (state_q != S_IDLE);
  assign m_arvalid    = (state_q == S_ADDR);
  assign m_rready     = (state_q == S_DATA) || (state_q == S_DRAIN);
  assign m_araddr     = addr_q;
  assign m_arprot     = 3'b100;

  // Fetch unit must wait for a response before issuing again.
  a_no_req_in_flight: assert property (@(posedge clock) disable iff (!reset_n)
    !(io_reqValid && ((state_q == S_ADDR) || (state_q == S_DATA))));

endmodule

// File: tb/tb_ifu_axi_rd.sv
// Directed + randomized bench for ifu_axi_rd acting as AXI slave; expected
// responses come from per-fetch arithmetic on handshake delays.
module tb_ifu_axi_rd;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_reqValid = 1'b0;
  logic [31:0] io_addr = 32'h0;
  logic        io_respValid;
  logic [31:0] io_rdata;
  logic        io_err;
  logic        busy;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic [1:0]  m_rresp = 2'b00;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  int total = 0;
  int bad = 0;

  ifu_axi_rd #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_reqValid(io_reqValid), .io_addr(io_addr),
    .io_respValid(io_respValid), .io_rdata(io_rdata), .io_err(io_err),
    .busy(busy),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, a[31:16] + 16'h0042};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".busy"},    64'(busy), 64'(0));
    chk({tag, ".arvalid"}, 64'(m_arvalid), 64'(0));
    chk({tag, ".rready"},  64'(m_rready), 64'(0));
    chk({tag, ".resp"},    64'(io_respValid), 64'(0));
    chk({tag, ".err"},     64'(io_err), 64'(0));
    chk({tag, ".rdata"},   64'(io_rdata), 64'(0));
    chk({tag, ".araddr"},  64'(m_araddr), 64'(0));
  endtask

  // One fetch at cycle 0; the bench plays the slave with ar_dly cycles of AR
  // backpressure and the beat r_dly cycles after the AR handshake. With inject,
  // a second aligned request pa is issued while draining a timed-out read.
  task automatic run_fetch(input string tag, input logic [31:0] a, input int ar_dly,
                           input int r_dly, input logic [31:0] rd, input logic [1:0] rr,
                           input bit inject, input logic [31:0] pa);
    bit aligned, tmo, exp_err, r_pend;
    int h, late, exp_cyc, inj_cyc, end_cyc, exp_n;
    int n_resp, n_ar, ar_cyc0, bad_addr, k, ar_wait, r_due;
    int rc[4];
    logic [31:0] rdv[4];
    logic rev[4];
    logic [31:0] exp_data, beat_data;
    logic [1:0] beat_resp;

    aligned  = (a[1:0] == 2'b00);
    h        = 1 + ar_dly;
    tmo      = aligned && (r_dly > TO);
    exp_cyc  = !aligned ? 1 : (tmo ? h + TO + 1 : h + r_dly + 1);
    exp_data = (aligned && !tmo) ? rd : 32'h0;
    exp_err  = !aligned || tmo || rr[1];
    late     = h + r_dly;
    inj_cyc  = h + TO + 2;
    exp_n    = inject ? 2 : 1;
    end_cyc  = inject ? late + 3 : exp_cyc;
    n_resp = 0; n_ar = 0; ar_cyc0 = 0; bad_addr = 0; k = 0; ar_wait = 0; r_due = 0;
    r_pend = 1'b0; beat_data = 32'h0; beat_resp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      rc[i] = -1; rdv[i] = 32'h0; rev[i] = 1'b0;
    end

    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clock);
      if (io_respValid) begin
        if (n_resp < 4) begin
          rc[n_resp] = cyc; rdv[n_resp] = io_rdata; rev[n_resp] = io_err;
        end
        n_resp++;
      end
      if (cyc > end_cyc && !busy && !r_pend) break;
      io_reqValid = (cyc == 0) || (inject && cyc == inj_cyc);
      io_addr     = (cyc == 0) ? a : (io_reqValid ? pa : 32'($urandom));
      if (r_pend && cyc >= r_due) begin
        m_rvalid = 1'b1; m_rdata = beat_data; m_rresp = beat_resp;
        if (m_rready) r_pend = 1'b0;
      end else begin
        m_rvalid = 1'b0; m_rdata = 32'($urandom); m_rresp = 2'($urandom);
      end
      if (m_arvalid) begin
        if (k == 0) ar_cyc0++;
        if (m_araddr !== ((k == 0) ? a : pa)) bad_addr++;
        m_arready = (ar_wait >= ((k == 0) ? ar_dly : 0));
        if (m_arready) begin
          n_ar++;
          r_pend    = 1'b1;
          r_due     = cyc + ((k == 0) ? r_dly : 1);
          beat_data = (k == 0) ? rd : mem_word(pa);
          beat_resp = (k == 0) ? rr : 2'b00;
          ar_wait   = 0;
          k++;
        end else begin
          ar_wait++;
        end
      end else begin
        m_arready = 1'($urandom);
      end
    end
    io_reqValid = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0;

    chk({tag, ".nresp"}, 64'(n_resp), 64'(exp_n));
    chk({tag, ".cyc"},   64'(rc[0]), 64'(exp_cyc));
    chk({tag, ".data"},  64'(rdv[0]), 64'(exp_data));
    chk({tag, ".err"},   64'(rev[0]), 64'(exp_err));
    if (inject) begin
      chk({tag, ".pend_cyc"},  64'(rc[1]), 64'(late + 3));
      chk({tag, ".pend_data"}, 64'(rdv[1]), 64'(mem_word(pa)));
      chk({tag, ".pend_err"},  64'(rev[1]), 64'(0));
    end
    chk({tag, ".nar"}, 64'(n_ar), 64'(aligned ? exp_n : 0));
    if (aligned) chk({tag, ".arcycles"}, 64'(ar_cyc0), 64'(ar_dly + 1));
    chk({tag, ".araddr"}, 64'(bad_addr), 64'(0));
    chk({tag, ".hold"}, 64'(io_rdata), 64'(inject ? mem_word(pa) : exp_data));
    chk({tag, ".idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [31:0] ra, rp;
    int rdl;
    bit mis, inj;

    #3;
    chk_reset_outputs("por");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("arprot", 64'(m_arprot), 64'(3'b100));

    run_fetch("basic",   32'h8000_0004, 0, 1, 32'h0010_0093, 2'b00, 1'b0, 32'h0);
    run_fetch("ar_bp",   32'h8000_0010, 5, 1, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0);
    run_fetch("slverr",  32'h8000_0020, 0, 2, 32'h1234_5678, 2'b10, 1'b0, 32'h0);
    run_fetch("okay",    32'h8000_0024, 0, 1, 32'h0000_0013, 2'b00, 1'b0, 32'h0);
    run_fetch("misalgn", 32'h8000_0002, 0, 1, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0);
    run_fetch("r_edge",  32'h8000_0030, 1, TO, 32'hCAFE_0001, 2'b00, 1'b0, 32'h0);
    run_fetch("tmo_min", 32'h8000_0034, 0, TO + 1, 32'hCAFE_0002, 2'b00, 1'b0, 32'h0);
    run_fetch("tmo_pend", 32'h8000_0040, 0, 14, 32'hCAFE_0003, 2'b00, 1'b1, 32'h0000_0100);

    for (int i = 0; i < 30; i++) begin
      ra  = 32'($urandom);
      mis = ($urandom_range(0, 3) == 0);
      ra[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
      rdl = $urandom_range(1, 13);
      inj = !mis && (rdl >= TO + 3) && ($urandom_range(0, 1) == 1);
      rp  = 32'($urandom);
      rp[1:0] = 2'b00;
      run_fetch($sformatf("rnd%0d", i), ra, $urandom_range(0, 4), rdl,
                32'($urandom), 2'($urandom), inj, rp);
    end

    run_fetch("pre_rst", 32'h8000_0050, 0, 1, 32'hA5A5_5A5A, 2'b00, 1'b0, 32'h0);
    @(negedge clock);
    io_reqValid = 1'b1; io_addr = 32'h0000_2000;
    @(negedge clock);
    io_reqValid = 1'b0; m_arready = 1'b1;
    @(negedge clock);
    m_arready = 1'b0;
    chk("mid_rst.in_data", 64'(m_rready), 64'(1));
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    @(negedge clock);
    reset_n = 1'b1;
    run_fetch("post_rst", 32'h0000_3000, 2, 3, 32'h0BAD_F00D, 2'b00, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
